// File: rtl/ram2_ctrl_pkg.sv
// Shared types for the RAM2 SRAM controller: FSM state encoding, strobe levels
// and state-class helpers used to derive the registered SRAM strobes.
package ram2_ctrl_pkg;

    localparam int  RAM2_ADDR_W = 20;
    localparam int  RAM2_DATA_W = 32;
    localparam logic STROBE_ON  = 1'b0;
    localparam logic STROBE_OFF = 1'b1;

    typedef enum logic [2:0] {
        R2_IDLE   = 3'd0,
        R2_RD_ACC = 3'd1,
        R2_RD_LAT = 3'd2,
        R2_WR_SET = 3'd3,
        R2_WR_PUL = 3'd4,
        R2_WR_HLD = 3'd5,
        R2_DONE   = 3'd6
    } r2_state_e;

    function automatic logic is_read(input r2_state_e s);
        return (s == R2_RD_ACC) || (s == R2_RD_LAT);
    endfunction

    function automatic logic is_write(input r2_state_e s);
        return (s == R2_WR_SET) || (s == R2_WR_PUL) || (s == R2_WR_HLD);
    endfunction

    function automatic logic is_access(input r2_state_e s);
        return is_read(s) || is_write(s);
    endfunction

endpackage

// File: rtl/ram2_ctrl_if.sv
// CPU-side (IF/MEM) and SRAM-side signals of the RAM2 controller. The slave
// modport is the controller's view; master is the CPU/SRAM environment's view.
interface ram2_ctrl_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 32
);
    logic              if_ce_i;
    logic [31:0]       if_addr_i;
    logic [DATA_W-1:0] inst_o;
    logic              mem_ce_i;
    logic              mem_we_i;
    logic [31:0]       mem_addr_i;
    logic [DATA_W-1:0] mem_data_i;
    logic [DATA_W-1:0] mem_data_o;
    logic              stallreq_o;
    logic [ADDR_W-1:0] ram_addr_o;
    logic [DATA_W-1:0] ram_data_o;
    logic              ram_data_oe_o;
    logic [DATA_W-1:0] ram_data_i;
    logic              ram_ce_n_o;
    logic              ram_oe_n_o;
    logic              ram_we_n_o;

    modport slave (
        input  if_ce_i, if_addr_i, mem_ce_i, mem_we_i, mem_addr_i, mem_data_i, ram_data_i,
        output inst_o, mem_data_o, stallreq_o, ram_addr_o, ram_data_o, ram_data_oe_o,
               ram_ce_n_o, ram_oe_n_o, ram_we_n_o
    );

    modport master (
        output if_ce_i, if_addr_i, mem_ce_i, mem_we_i, mem_addr_i, mem_data_i, ram_data_i,
        input  inst_o, mem_data_o, stallreq_o, ram_addr_o, ram_data_o, ram_data_oe_o,
               ram_ce_n_o, ram_oe_n_o, ram_we_n_o
    );
endinterface

// File: rtl/ram2_ctrl.sv
// Single-port RAM2 controller: arbitrates fetch and data accesses (data first),
// sequences 2-cycle reads / 3-cycle writes and stalls the pipeline until done.
module ram2_ctrl
    import ram2_ctrl_pkg::*;
#(
    parameter int ADDR_W = RAM2_ADDR_W,
    parameter int DATA_W = RAM2_DATA_W
) (
    input  logic      clk,
    input  logic      rst,
    ram2_ctrl_if.slave bus,
    output r2_state_e o_dbg_state
);

    r2_state_e         r_state;
    logic              r_pend_if;
    logic              r_pend_mem;
    logic              r_cur_mem;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_if_waddr;
    logic [ADDR_W-1:0] r_mem_waddr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_data;
    logic              r_ram_data_oe;
    logic              r_ce_n;
    logic              r_oe_n;
    logic              r_we_n;
    logic [DATA_W-1:0] r_inst;
    logic [DATA_W-1:0] r_mem_data;

    r2_state_e         w_next;
    logic              w_start;
    logic              w_start_mem;
    logic              w_start_wr;
    logic [ADDR_W-1:0] w_if_waddr;
    logic [ADDR_W-1:0] w_mem_waddr;
    logic [DATA_W-1:0] w_mem_wdata;
    logic              w_unused_bits;

    // In IDLE the first access is launched straight from the request inputs;
    // afterwards only the values captured in IDLE are used.
    assign w_if_waddr  = (r_state == R2_IDLE) ? bus.if_addr_i[ADDR_W+1:2]  : r_if_waddr;
    assign w_mem_waddr = (r_state == R2_IDLE) ? bus.mem_addr_i[ADDR_W+1:2] : r_mem_waddr;
    assign w_mem_wdata = (r_state == R2_IDLE) ? bus.mem_data_i : r_mem_wdata;
    assign w_unused_bits = ^{bus.if_addr_i[31:ADDR_W+2], bus.if_addr_i[1:0],
                             bus.mem_addr_i[31:ADDR_W+2], bus.mem_addr_i[1:0]};

    always_comb begin
        w_next      = r_state;
        w_start     = 1'b0;
        w_start_mem = 1'b0;
        w_start_wr  = 1'b0;
        case (r_state)
            R2_IDLE: begin
                if (bus.mem_ce_i) begin
                    w_start     = 1'b1;
                    w_start_mem = 1'b1;
                    w_start_wr  = bus.mem_we_i;
                end else if (bus.if_ce_i) begin
                    w_start = 1'b1;
                end
            end
            R2_RD_ACC: w_next = R2_RD_LAT;
            R2_WR_SET: w_next = R2_WR_PUL;
            R2_WR_PUL: w_next = R2_WR_HLD;
            R2_RD_LAT, R2_WR_HLD: begin
                if (r_cur_mem && r_pend_if) begin
                    w_start = 1'b1;
                end else if (!r_cur_mem && r_pend_mem) begin
                    w_start     = 1'b1;
                    w_start_mem = 1'b1;
                    w_start_wr  = r_mem_we;
                end else begin
                    w_next = R2_DONE;
                end
            end
            R2_DONE: w_next = R2_IDLE;
            default: w_next = R2_IDLE;
        endcase
        if (w_start) begin
            w_next = w_start_wr ? R2_WR_SET : R2_RD_ACC;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= R2_IDLE;
            r_pend_if     <= 1'b0;
            r_pend_mem    <= 1'b0;
            r_cur_mem     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_if_waddr    <= '0;
            r_mem_waddr   <= '0;
            r_mem_wdata   <= '0;
            r_ram_addr    <= '0;
            r_ram_data    <= '0;
            r_ram_data_oe <= 1'b0;
            r_ce_n        <= STROBE_OFF;
            r_oe_n        <= STROBE_OFF;
            r_we_n        <= STROBE_OFF;
            r_inst        <= '0;
            r_mem_data    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == R2_IDLE) begin
                r_pend_if   <= bus.if_ce_i;
                r_pend_mem  <= bus.mem_ce_i;
                r_mem_we    <= bus.mem_we_i;
                r_if_waddr  <= w_if_waddr;
                r_mem_waddr <= w_mem_waddr;
                r_mem_wdata <= w_mem_wdata;
            end
            if (r_state == R2_RD_LAT || r_state == R2_WR_HLD) begin
                if (r_cur_mem) r_pend_mem <= 1'b0;
                else           r_pend_if  <= 1'b0;
            end
            if (r_state == R2_RD_LAT) begin
                if (r_cur_mem) r_mem_data <= bus.ram_data_i;
                else           r_inst     <= bus.ram_data_i;
            end
            if (w_start) begin
                r_cur_mem  <= w_start_mem;
                r_ram_addr <= w_start_mem ? w_mem_waddr : w_if_waddr;
                if (w_start_wr) r_ram_data <= w_mem_wdata;
            end
            // Strobes follow the state being entered so they line up with it.
            r_ce_n        <= is_access(w_next) ? STROBE_ON : STROBE_OFF;
            r_oe_n        <= is_read(w_next)   ? STROBE_ON : STROBE_OFF;
            r_we_n        <= (w_next == R2_WR_PUL) ? STROBE_ON : STROBE_OFF;
            r_ram_data_oe <= is_write(w_next);
        end
    end

    assign bus.stallreq_o    = (r_state == R2_IDLE) ? (bus.if_ce_i | bus.mem_ce_i)
                                                    : (r_state != R2_DONE);
    assign bus.inst_o        = r_inst;
    assign bus.mem_data_o    = r_mem_data;
    assign bus.ram_addr_o    = r_ram_addr;
    assign bus.ram_data_o    = r_ram_data;
    assign bus.ram_data_oe_o = r_ram_data_oe;
    assign bus.ram_ce_n_o    = r_ce_n;
    assign bus.ram_oe_n_o    = r_oe_n;
    assign bus.ram_we_n_o    = r_we_n;
    assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_ram2_ctrl.sv
// Directed bench for ram2_ctrl with an SRAM model, scoreboard queues and a
// monitor that checks results, latencies, strobe counts and SRAM addresses.
module tb_ram2_ctrl;
    import ram2_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram2_ctrl_if bus ();
    r2_state_e   dbg_state;

    ram2_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .o_dbg_state(dbg_state)
    );

    int vectors     = 0;
    int miscompares = 0;

    // {inst[79:48], mem_data[47:16], stall[15:12], we_low[11:8], data_oe[7:4], rd[3:0]}
    logic [79:0] exp_q[$];
    logic [19:0] addr_q[$];
    logic [31:0] wdata_q[$];

    logic [31:0] sram [0:255];

    assign bus.ram_data_i = (!bus.ram_ce_n_o && !bus.ram_oe_n_o) ? sram[bus.ram_addr_o[7:0]] : 32'h0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: got no event expected one", name);
    endtask

    // SRAM model: a write lands when we_n rises while ce_n is still low.
    initial begin
        logic prev_we_low;
        prev_we_low = 1'b0;
        for (int i = 0; i < 256; i++) sram[i] = 32'h0;
        sram[3]  = 32'h8C43_0003;
        sram[4]  = 32'h2408_0001;
        sram[16] = 32'hA5A5_0040;
        sram[17] = 32'h3C00_0044;
        sram[20] = 32'h1234_5678;
        forever begin
            @(negedge clk);
            if (prev_we_low && !bus.ram_ce_n_o && bus.ram_we_n_o)
                sram[bus.ram_addr_o[7:0]] = bus.ram_data_o;
            prev_we_low = !bus.ram_ce_n_o && !bus.ram_we_n_o && bus.ram_data_oe_o;
        end
    end

    // Monitor
    initial begin
        int stall_cnt, we_cnt, doe_cnt, rd_cnt;
        logic [79:0] e;
        stall_cnt = 0; we_cnt = 0; doe_cnt = 0; rd_cnt = 0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                stall_cnt = 0; we_cnt = 0; doe_cnt = 0; rd_cnt = 0;
            end else begin
                check("bus_conflict", 64'(!bus.ram_oe_n_o && bus.ram_data_oe_o), 64'd0);
                if (bus.stallreq_o) stall_cnt++;
                if (!bus.ram_ce_n_o && !bus.ram_we_n_o) we_cnt++;
                if (bus.ram_data_oe_o) doe_cnt++;
                if (!bus.ram_ce_n_o && !bus.ram_oe_n_o) rd_cnt++;
                if (dbg_state == R2_RD_ACC || dbg_state == R2_WR_SET) begin
                    if (addr_q.size() == 0) fail_now("ram_addr_unexpected");
                    else check("ram_addr", 64'(bus.ram_addr_o), 64'(addr_q.pop_front()));
                end
                if (dbg_state == R2_WR_SET) begin
                    if (wdata_q.size() == 0) fail_now("ram_wdata_unexpected");
                    else check("ram_wdata", 64'(bus.ram_data_o), 64'(wdata_q.pop_front()));
                end
                if (dbg_state == R2_DONE) begin
                    if (exp_q.size() == 0) begin
                        fail_now("done_unexpected");
                    end else begin
                        e = exp_q.pop_front();
                        check("inst_o",      64'(bus.inst_o),     64'(e[79:48]));
                        check("mem_data_o",  64'(bus.mem_data_o), 64'(e[47:16]));
                        check("stall_cycles", 64'(stall_cnt),     64'(e[15:12]));
                        check("we_low_cycles", 64'(we_cnt),       64'(e[11:8]));
                        check("data_oe_cycles", 64'(doe_cnt),     64'(e[7:4]));
                        check("read_cycles", 64'(rd_cnt),         64'(e[3:0]));
                        check("stall_in_done", 64'(bus.stallreq_o), 64'd0);
                    end
                    stall_cnt = 0; we_cnt = 0; doe_cnt = 0; rd_cnt = 0;
                end
            end
        end
    end

    task automatic push_exp(input logic [31:0] inst, input logic [31:0] mdata,
                            input int stall, input int we, input int doe, input int rd);
        exp_q.push_back({inst, mdata, 4'(stall), 4'(we), 4'(doe), 4'(rd)});
    endtask

    task automatic wait_state(input r2_state_e s, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (dbg_state == s) return;
        end
        fail_now(name);
    endtask

    task automatic drive_req(input logic ice, input logic [31:0] iaddr, input logic mce,
                             input logic mwe, input logic [31:0] maddr, input logic [31:0] mdata);
        wait_state(R2_IDLE, 20, "idle_timeout");
        bus.if_ce_i    = ice;
        bus.if_addr_i  = iaddr;
        bus.mem_ce_i   = mce;
        bus.mem_we_i   = mwe;
        bus.mem_addr_i = maddr;
        bus.mem_data_i = mdata;
        @(negedge clk);
        bus.if_ce_i    = 1'b0;
        bus.mem_ce_i   = 1'b0;
        bus.if_addr_i  = $urandom_range(32'hFFFF, 0);
        bus.mem_addr_i = $urandom_range(32'hFFFF, 0);
        bus.mem_data_i = $urandom_range(32'hFFFF, 0);
        bus.mem_we_i   = 1'($urandom_range(1, 0));
    endtask

    task automatic issue(input logic ice, input logic [31:0] iaddr, input logic mce,
                         input logic mwe, input logic [31:0] maddr, input logic [31:0] mdata);
        drive_req(ice, iaddr, mce, mwe, maddr, mdata);
        wait_state(R2_DONE, 20, "done_timeout");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, dones;
        bus.if_ce_i = 1'b0; bus.if_addr_i = '0;
        bus.mem_ce_i = 1'b0; bus.mem_we_i = 1'b0; bus.mem_addr_i = '0; bus.mem_data_i = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_state",   64'(dbg_state),          64'(R2_IDLE));
        check("rst_ce_n",    64'(bus.ram_ce_n_o),     64'd1);
        check("rst_oe_n",    64'(bus.ram_oe_n_o),     64'd1);
        check("rst_we_n",    64'(bus.ram_we_n_o),     64'd1);
        check("rst_data_oe", 64'(bus.ram_data_oe_o),  64'd0);
        check("rst_outputs", {bus.inst_o, bus.mem_data_o}, 64'd0);
        check("rst_ram_bus", {12'd0, bus.ram_addr_o, bus.ram_data_o}, 64'd0);
        check("rst_stall",   64'(bus.stallreq_o),     64'd0);
        rst = 1'b0;

        // Fetch 0x10 -> word 4
        addr_q.push_back(20'd4);
        push_exp(32'h2408_0001, 32'h0, 3, 0, 0, 2);
        issue(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);

        // Store 0x20 <- DEADBEEF, then load it back
        addr_q.push_back(20'd8); wdata_q.push_back(32'hDEAD_BEEF);
        push_exp(32'h2408_0001, 32'h0, 4, 1, 3, 0);
        issue(1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 32'hDEAD_BEEF);
        addr_q.push_back(20'd8);
        push_exp(32'h2408_0001, 32'hDEAD_BEEF, 3, 0, 0, 2);
        issue(1'b0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);

        // Load 0x40 + fetch 0x44: data first
        addr_q.push_back(20'd16); addr_q.push_back(20'd17);
        push_exp(32'h3C00_0044, 32'hA5A5_0040, 5, 0, 0, 4);
        issue(1'b1, 32'h44, 1'b1, 1'b0, 32'h40, 32'h0);

        // Store 0x48 + fetch 0x0C; mem_data_o must not change
        addr_q.push_back(20'd18); addr_q.push_back(20'd3); wdata_q.push_back(32'h0BAD_F00D);
        push_exp(32'h8C43_0003, 32'hA5A5_0040, 6, 1, 3, 2);
        issue(1'b1, 32'h0C, 1'b1, 1'b1, 32'h48, 32'h0BAD_F00D);
        addr_q.push_back(20'd18);
        push_exp(32'h8C43_0003, 32'h0BAD_F00D, 3, 0, 0, 2);
        issue(1'b0, 32'h0, 1'b1, 1'b0, 32'h4A, 32'h0);

        // Back-to-back fetches with if_ce_i held; low address bits ignored
        for (int i = 0; i < 3; i++) begin
            addr_q.push_back(20'd20);
            push_exp(32'h1234_5678, 32'h0BAD_F00D, 3, 0, 0, 2);
        end
        wait_state(R2_IDLE, 20, "idle_timeout");
        bus.if_ce_i = 1'b1; bus.if_addr_i = 32'h53;
        cyc = 0; dones = 0;
        while (dones < 3 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (dbg_state == R2_DONE) dones++;
        end
        bus.if_ce_i = 1'b0;
        check("b2b_cycles", 64'(cyc), 64'd11);

        // Reset during WR_PUL of a store to word 8
        addr_q.push_back(20'd8); wdata_q.push_back(32'hFFFF_0000);
        drive_req(1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 32'hFFFF_0000);
        wait_state(R2_WR_PUL, 10, "wr_pul_timeout");
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("mid_rst_state",   64'(dbg_state),         64'(R2_IDLE));
        check("mid_rst_strobes", {61'd0, bus.ram_ce_n_o, bus.ram_oe_n_o, bus.ram_we_n_o}, 64'd7);
        check("mid_rst_data_oe", 64'(bus.ram_data_oe_o), 64'd0);
        check("mid_rst_outputs", {bus.inst_o, bus.mem_data_o}, 64'd0);
        check("mid_rst_ram_bus", {12'd0, bus.ram_addr_o, bus.ram_data_o}, 64'd0);
        check("mid_rst_stall",   64'(bus.stallreq_o),    64'd0);
        rst = 1'b0;
        addr_q.push_back(20'd8);
        push_exp(32'h0, 32'hDEAD_BEEF, 3, 0, 0, 2);
        issue(1'b0, 32'h0, 1'b1, 1'b0, 32'h22, 32'h0);

        repeat (4) @(negedge clk);
        check("exp_q_drained",   64'(exp_q.size()),   64'd0);
        check("addr_q_drained",  64'(addr_q.size()),  64'd0);
        check("wdata_q_drained", 64'(wdata_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
